// File: rtl/door_access_controller_pkg.sv
// Shared definitions for the door access controller and the keypad entry stage
// that watches busy/state.
package door_access_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UNLOCK  = 2'd1,
        ST_DENY    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [3:0] USER_NONE   = 4'd0;
    localparam int         NUM_USERS   = 10;
    localparam int         ALARM_DIV_W = 22;

endpackage

// File: rtl/door_access_controller_timer.sv
// Loadable down counter with a registered zero flag; it stops at zero
// instead of wrapping, so an idle timer stays at zero.
module door_access_controller_timer #(
    parameter int TMR_W = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - ONE;
            zero  <= (count == ONE);
        end
    end

endmodule

// File: rtl/door_access_controller.sv
// Samples the password comparator on each check strobe and drives the door
// release, deny indication and failure lockout with buzzer alarm.
module door_access_controller
    import door_access_controller_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = 250_000_000,
    parameter int DENY_CYCLES    = 50_000_000,
    parameter int LOCKOUT_CYCLES = 1_500_000_000,
    parameter int MAX_FAIL       = 3,
    parameter int TMR_W          = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       check_req,
    input  logic [9:0] match_sw,
    input  logic       match_success,
    input  logic       admin_clear,
    output logic       door_unlock,
    output logic       deny,
    output logic       lockout,
    output logic       alarm,
    output logic [3:0] user_id,
    output logic [3:0] fail_count,
    output logic       busy
);

    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] DENY_LOAD    = TMR_W'(DENY_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [4:0]       MAX_FAIL_5   = 5'(MAX_FAIL);
    localparam logic [3:0]       MAX_FAIL_4   = 4'(MAX_FAIL);

    function automatic logic is_one_hot(input logic [NUM_USERS-1:0] v);
        return (v != '0) && ((v & (v - NUM_USERS'(1))) == '0);
    endfunction

    function automatic logic [3:0] onehot_index(input logic [NUM_USERS-1:0] v);
        logic [3:0] idx;
        idx = USER_NONE;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (v[i]) idx = 4'(i + 1);
        end
        return idx;
    endfunction

    state_t                 state;
    logic                   accept;
    logic [4:0]             fail_next;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_load_val;
    logic                   tmr_zero;
    logic [ALARM_DIV_W-1:0] alarm_div;

    // admin_clear zeroes the timer when it aborts DENY/LOCKOUT; a clear in UNLOCK leaves it running
    always_comb begin
        accept       = check_req && match_success && is_one_hot(match_sw);
        fail_next    = {1'b0, fail_count} + 5'd1;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (admin_clear) begin
            tmr_load = (state == ST_DENY) || (state == ST_LOCKOUT);
        end else if (check_req) begin
            case (state)
                ST_IDLE: begin
                    tmr_load = 1'b1;
                    if (accept)                     tmr_load_val = UNLOCK_LOAD;
                    else if (fail_next >= MAX_FAIL_5) tmr_load_val = LOCKOUT_LOAD;
                    else                            tmr_load_val = DENY_LOAD;
                end
                ST_UNLOCK: begin
                    if (accept) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = UNLOCK_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    door_access_controller_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            door_unlock <= 1'b0;
            deny        <= 1'b0;
            lockout     <= 1'b0;
            alarm       <= 1'b0;
            user_id     <= USER_NONE;
            fail_count  <= '0;
            busy        <= 1'b0;
            alarm_div   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (admin_clear) begin
                        fail_count <= '0;
                    end else if (check_req) begin
                        busy <= 1'b1;
                        if (accept) begin
                            state       <= ST_UNLOCK;
                            door_unlock <= 1'b1;
                            user_id     <= onehot_index(match_sw);
                            fail_count  <= '0;
                        end else if (fail_next >= MAX_FAIL_5) begin
                            state      <= ST_LOCKOUT;
                            lockout    <= 1'b1;
                            alarm      <= 1'b1;
                            alarm_div  <= '0;
                            fail_count <= MAX_FAIL_4;
                        end else begin
                            state      <= ST_DENY;
                            deny       <= 1'b1;
                            fail_count <= fail_next[3:0];
                        end
                    end
                end
                ST_UNLOCK: begin
                    if (admin_clear) fail_count <= '0;
                    // A fresh valid check extends the release; failed checks are ignored here
                    if (!admin_clear && accept) begin
                        user_id <= onehot_index(match_sw);
                    end else if (tmr_zero) begin
                        state       <= ST_IDLE;
                        door_unlock <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                ST_DENY: begin
                    if (admin_clear || tmr_zero) begin
                        state <= ST_IDLE;
                        deny  <= 1'b0;
                        busy  <= 1'b0;
                        if (admin_clear) fail_count <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    if (admin_clear || tmr_zero) begin
                        state      <= ST_IDLE;
                        lockout    <= 1'b0;
                        alarm      <= 1'b0;
                        busy       <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        alarm_div <= alarm_div + ALARM_DIV_W'(1);
                        if (&alarm_div) alarm <= ~alarm;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
